// File: rtl/bsram_mp.sv
// bsram_mp: multi-read-port block SRAM with byte-lane writes and a zero-fill
// sequence that runs after reset.
//
// State table:
//   ST_CLEAR | walking clear_addr_q over the array writing zeros; ready=0
//   ST_READY | array usable; external writes and reads accepted
//
// Ports:
//   clock, reset            rising-edge clock, async active-high reset
//   ready                   high once the array is usable (registered)
//   readEnable/Address      per-port request; port p at [p*ADDR_WIDTH +: ADDR_WIDTH]
//   readData/readValid      per-port response, packed like the addresses
//   writeEnable/ByteEnable  write request and byte-lane mask
//   writeAddress/writeData  write word address and data
//   report                  per-cycle status print (simulation only)
module bsram_mp #(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 8,
    parameter int NUM_READ_PORTS = 2,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                                 clock,
    input  logic                                 reset,
    output logic                                 ready,
    input  logic [NUM_READ_PORTS-1:0]            readEnable,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] readAddress,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] readData,
    output logic [NUM_READ_PORTS-1:0]            readValid,
    input  logic                                 writeEnable,
    input  logic [DATA_WIDTH/8-1:0]              writeByteEnable,
    input  logic [ADDR_WIDTH-1:0]                writeAddress,
    input  logic [DATA_WIDTH-1:0]                writeData,
    input  logic                                 report
);

    localparam int MEM_DEPTH = 1 << ADDR_WIDTH;
    localparam int NB        = DATA_WIDTH / 8;

    typedef enum logic {ST_CLEAR, ST_READY} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   clear_addr_q;
    logic                    ready_q;
    logic [31:0]             cycle_q;
    logic [DATA_WIDTH-1:0]   sram [MEM_DEPTH];

    logic                    write_go;
    logic [NUM_READ_PORTS-1:0] rd_go;
    logic [ADDR_WIDTH-1:0]   rd_addr  [NUM_READ_PORTS];
    logic [DATA_WIDTH-1:0]   byp_word [NUM_READ_PORTS];

    // ready_q doubles as the access gate, so with CLEAR_ON_RESET=0 nothing
    // is accepted until the first edge after reset release.
    assign ready    = ready_q;
    assign write_go = writeEnable & ready_q;
    assign rd_go    = readEnable & {NUM_READ_PORTS{ready_q}};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
            clear_addr_q <= '0;
            ready_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clear_addr_q <= clear_addr_q + 1'b1;
                    if (clear_addr_q == '1) begin
                        state_q <= ST_READY;
                        ready_q <= 1'b1;
                    end
                end
                default: ready_q <= 1'b1;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) cycle_q <= '0;
        else       cycle_q <= cycle_q + 32'd1;
    end

    // Array has no reset; contents survive the reset edge until zero-filled.
    always_ff @(posedge clock) begin
        if (state_q == ST_CLEAR) begin
            sram[clear_addr_q] <= '0;
        end else if (write_go) begin
            for (int b = 0; b < NB; b++) begin
                if (writeByteEnable[b])
                    sram[writeAddress][8*b +: 8] <= writeData[8*b +: 8];
            end
        end
    end

    for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : g_addr
        assign rd_addr[p] = readAddress[p*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Same-cycle write to the read address is merged lane by lane so a read
    // always sees the post-write word.
    always_comb begin
        for (int p = 0; p < NUM_READ_PORTS; p++) begin
            byp_word[p] = sram[rd_addr[p]];
            for (int b = 0; b < NB; b++) begin
                if (write_go && writeByteEnable[b] && (writeAddress == rd_addr[p]))
                    byp_word[p][8*b +: 8] = writeData[8*b +: 8];
            end
        end
    end

    if (READ_LATENCY == 0) begin : g_lat0
        always_comb begin
            readData = '0;
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                if (rd_go[p]) readData[p*DATA_WIDTH +: DATA_WIDTH] = byp_word[p];
            end
        end
        assign readValid = rd_go;
    end else begin : g_lat1
        logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rdata_q;
        logic [NUM_READ_PORTS-1:0]            rvalid_q;

        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                rdata_q  <= '0;
                rvalid_q <= '0;
            end else begin
                rvalid_q <= rd_go;
                for (int p = 0; p < NUM_READ_PORTS; p++) begin
                    rdata_q[p*DATA_WIDTH +: DATA_WIDTH] <= rd_go[p] ? byp_word[p] : '0;
                end
            end
        end
        assign readData  = rdata_q;
        assign readValid = rvalid_q;
    end

`ifndef SYNTHESIS
    always @(posedge clock) begin
        if (report) begin
            $display("bsram_mp core=%0d cycle=%0d state=%s we=%b wbe=%b waddr=%h wdata=%h",
                     CORE, cycle_q, state_q.name(), writeEnable, writeByteEnable,
                     writeAddress, writeData);
            for (int p = 0; p < NUM_READ_PORTS; p++) begin
                $display("  port%0d en=%b addr=%h data=%h valid=%b", p, readEnable[p],
                         rd_addr[p], readData[p*DATA_WIDTH +: DATA_WIDTH], readValid[p]);
            end
        end
    end
`endif

endmodule

// File: tb/tb_bsram_mp.sv
module tb_bsram_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // DUT A: registered read, zero-fill on reset
    logic        a_rst, a_ready, a_we;
    logic [1:0]  a_re, a_rvalid;
    logic [15:0] a_raddr;
    logic [63:0] a_rdata;
    logic [3:0]  a_wbe;
    logic [7:0]  a_waddr;
    logic [31:0] a_wdata;

    // DUT B: combinational read, no zero-fill
    logic        b_rst, b_ready, b_we;
    logic [1:0]  b_re, b_rvalid;
    logic [15:0] b_raddr;
    logic [63:0] b_rdata;
    logic [3:0]  b_wbe;
    logic [7:0]  b_waddr;
    logic [31:0] b_wdata;

    logic [31:0] qa [2][$];
    logic [31:0] qb [2][$];

    bsram_mp #(.CORE(0), .READ_LATENCY(1), .CLEAR_ON_RESET(1)) u_a (
        .clock(clk), .reset(a_rst), .ready(a_ready),
        .readEnable(a_re), .readAddress(a_raddr), .readData(a_rdata), .readValid(a_rvalid),
        .writeEnable(a_we), .writeByteEnable(a_wbe), .writeAddress(a_waddr),
        .writeData(a_wdata), .report(1'b0)
    );

    bsram_mp #(.CORE(1), .READ_LATENCY(0), .CLEAR_ON_RESET(0)) u_b (
        .clock(clk), .reset(b_rst), .ready(b_ready),
        .readEnable(b_re), .readAddress(b_raddr), .readData(b_rdata), .readValid(b_rvalid),
        .writeEnable(b_we), .writeByteEnable(b_wbe), .writeAddress(b_waddr),
        .writeData(b_wdata), .report(1'b0)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitors: pop the expected word whenever a port presents valid data.
    always @(negedge clk) begin
        logic [31:0] e;
        for (int p = 0; p < 2; p++) begin
            if (a_rvalid[p] === 1'b1) begin
                checks++;
                if (qa[p].size() == 0) begin
                    errors++;
                    $display("FAIL a_unexpected_valid port%0d: got data %h expected no valid", p, a_rdata[p*32 +: 32]);
                end else begin
                    e = qa[p].pop_front();
                    if (a_rdata[p*32 +: 32] !== e) begin
                        errors++;
                        $display("FAIL a_read port%0d: got %h expected %h", p, a_rdata[p*32 +: 32], e);
                    end
                end
            end
            if (b_rvalid[p] === 1'b1) begin
                checks++;
                if (qb[p].size() == 0) begin
                    errors++;
                    $display("FAIL b_unexpected_valid port%0d: got data %h expected no valid", p, b_rdata[p*32 +: 32]);
                end else begin
                    e = qb[p].pop_front();
                    if (b_rdata[p*32 +: 32] !== e) begin
                        errors++;
                        $display("FAIL b_read port%0d: got %h expected %h", p, b_rdata[p*32 +: 32], e);
                    end
                end
            end
        end
    end

    task automatic a_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] mask);
        a_we = 1'b1; a_waddr = addr; a_wdata = data; a_wbe = mask;
        tick();
        a_we = 1'b0; a_wbe = 4'h0;
    endtask

    task automatic a_read(input logic [1:0] en, input logic [7:0] ad0, input logic [7:0] ad1,
                          input logic [31:0] e0, input logic [31:0] e1);
        a_re = en; a_raddr = {ad1, ad0};
        if (en[0]) qa[0].push_back(e0);
        if (en[1]) qa[1].push_back(e1);
        tick();
        a_re = 2'b00;
    endtask

    task automatic b_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] mask);
        b_we = 1'b1; b_waddr = addr; b_wdata = data; b_wbe = mask;
        tick();
        b_we = 1'b0; b_wbe = 4'h0;
    endtask

    task automatic b_read(input logic [1:0] en, input logic [7:0] ad0, input logic [7:0] ad1,
                          input logic [31:0] e0, input logic [31:0] e1);
        b_re = en; b_raddr = {ad1, ad0};
        if (en[0]) qb[0].push_back(e0);
        if (en[1]) qb[1].push_back(e1);
        tick();
        b_re = 2'b00;
    endtask

    // Runs the 256-cycle zero-fill on DUT A from cycle 0 (just after reset
    // release), holding reads and optionally attempting a write to addr 200.
    task automatic a_clear_seq(input bit do_write);
        int bad_ready = 0;
        int bad_valid = 0;
        int bad_data  = 0;
        for (int i = 0; i < 256; i++) begin
            if (a_ready !== 1'b0) bad_ready++;
            if (a_rvalid !== 2'b00) bad_valid++;
            if (a_rdata !== 64'h0) bad_data++;
            if (i == 5) begin a_re = 2'b11; a_raddr = {8'd5, 8'd5}; end
            if (i == 255) a_re = 2'b00;
            if (do_write && i == 250) begin
                a_we = 1'b1; a_waddr = 8'd200; a_wdata = 32'hFFFFFFFF; a_wbe = 4'hF;
            end
            if (do_write && i == 251) begin a_we = 1'b0; a_wbe = 4'h0; end
            tick();
        end
        check("a_ready_low_cycles_0_255", bad_ready, 0);
        check("a_no_valid_during_clear", bad_valid, 0);
        check("a_zero_data_during_clear", bad_data, 0);
        check("a_ready_at_cycle_256", {31'b0, a_ready}, 1);
    endtask

    initial begin
        a_rst = 1'b1; a_re = '0; a_raddr = '0; a_we = 1'b0; a_wbe = '0; a_waddr = '0; a_wdata = '0;
        b_rst = 1'b1; b_re = '0; b_raddr = '0; b_we = 1'b0; b_wbe = '0; b_waddr = '0; b_wdata = '0;
        tick();
        tick();
        check("a_reset_ready", {31'b0, a_ready}, 0);
        check("a_reset_valid", {30'b0, a_rvalid}, 0);
        check("a_reset_data_p0", a_rdata[31:0], 0);
        check("a_reset_data_p1", a_rdata[63:32], 0);

        // first zero-fill, then preload addr 5
        a_rst = 1'b0;
        a_clear_seq(1'b0);
        a_write(8'd5, 32'hDEADBEEF, 4'hF);
        a_read(2'b01, 8'd5, 8'd0, 32'hDEADBEEF, 32'h0);

        // byte-masked write
        a_write(8'd3, 32'h11223344, 4'hF);
        a_write(8'd3, 32'hAABBCCDD, 4'b0101);
        a_read(2'b10, 8'd0, 8'd3, 32'h0, 32'h11BB33DD);

        // bypass: both ports read addr 7 during a masked write to it
        a_write(8'd7, 32'h12345678, 4'hF);
        a_we = 1'b1; a_waddr = 8'd7; a_wdata = 32'hCAFEF00D; a_wbe = 4'b0011;
        a_re = 2'b11; a_raddr = {8'd7, 8'd7};
        qa[0].push_back(32'h1234F00D);
        qa[1].push_back(32'h1234F00D);
        tick();
        a_we = 1'b0; a_wbe = 4'h0; a_re = 2'b00;
        #3;
        check("a_bypass_valid_both", {30'b0, a_rvalid}, 2'b11);
        tick();

        // write to a different address does not disturb a read
        a_we = 1'b1; a_waddr = 8'd8; a_wdata = 32'h55555555; a_wbe = 4'hF;
        a_re = 2'b11; a_raddr = {8'd7, 8'd8};
        qa[0].push_back(32'h55555555);
        qa[1].push_back(32'h1234F00D);
        tick();
        a_we = 1'b0; a_wbe = 4'h0; a_re = 2'b00;
        tick();

        // reset again, then reset once more at clear cycle 100
        a_rst = 1'b1;
        #1;
        check("a_async_reset_ready", {31'b0, a_ready}, 0);
        tick();
        a_rst = 1'b0;
        for (int i = 0; i < 100; i++) tick();
        a_rst = 1'b1;
        tick();
        tick();
        a_rst = 1'b0;
        a_clear_seq(1'b1);
        a_read(2'b11, 8'd5, 8'd200, 32'h0, 32'h0);
        a_read(2'b01, 8'd3, 8'd0, 32'h0, 32'h0);
        tick();

        // DUT B: no zero-fill, combinational read
        check("b_reset_ready", {31'b0, b_ready}, 0);
        b_rst = 1'b0;
        #1;
        check("b_ready_cycle0", {31'b0, b_ready}, 0);
        tick();
        check("b_ready_first_edge", {31'b0, b_ready}, 1);

        b_write(8'd1, 32'h0000000A, 4'hF);
        b_write(8'd2, 32'h0000000B, 4'hF);
        b_re = 2'b11; b_raddr = {8'd2, 8'd1};
        qb[0].push_back(32'hA);
        qb[1].push_back(32'hB);
        #1;
        check("b_valid_both", {30'b0, b_rvalid}, 2'b11);
        tick();
        b_re = 2'b01; b_raddr = {8'd2, 8'd1};
        qb[0].push_back(32'hA);
        #1;
        check("b_valid_p1_off", {30'b0, b_rvalid}, 2'b01);
        check("b_data_p1_off", b_rdata[63:32], 0);
        tick();
        b_re = 2'b00;

        // top of the address range and no aliasing onto addr 0
        b_write(8'hFF, 32'h5A5AA5A5, 4'hF);
        b_write(8'h00, 32'h00000077, 4'hF);
        b_read(2'b11, 8'hFF, 8'h00, 32'h5A5AA5A5, 32'h00000077);

        // combinational bypass
        b_write(8'd9, 32'h00000000, 4'hF);
        b_we = 1'b1; b_waddr = 8'd9; b_wdata = 32'hABCDEF12; b_wbe = 4'b1000;
        b_read(2'b01, 8'd9, 8'd0, 32'hAB000000, 32'h0);
        b_we = 1'b0; b_wbe = 4'h0;
        b_read(2'b10, 8'd0, 8'd9, 32'h0, 32'hAB000000);

        tick();
        tick();
        check("a_queue0_drained", qa[0].size(), 0);
        check("a_queue1_drained", qa[1].size(), 0);
        check("b_queue0_drained", qb[0].size(), 0);
        check("b_queue1_drained", qb[1].size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bsram_mp.md
Name: bsram_mp

Overview:
- Parametrised multi-read-port block SRAM; the next-generation data/instruction memory for the BRISC-V cores.
- Adds N independent read ports, byte-lane write enables, selectable read latency (0 = same-cycle, 1 = registered), and a hardware zero-fill sequence after reset.
- The zero-fill removes the dependence on a zeros init file.
- Sits between the core's fetch/memory stages and the memory interface.

Parameters:
CORE, 0, core index printed in report output
DATA_WIDTH, 32, word width; must be a multiple of 8
ADDR_WIDTH, 8, word address width; MEM_DEPTH = 1<<ADDR_WIDTH
NUM_READ_PORTS, 2, number of independent read ports (1..4)
READ_LATENCY, 1, 0 = combinational read, 1 = registered read
CLEAR_ON_RESET, 1, 1 = zero-fill the array after reset; 0 = ready immediately

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
ready  out  1  high once the array is usable
readEnable  in  NUM_READ_PORTS  per-port read request
readAddress  in  NUM_READ_PORTS*ADDR_WIDTH  per-port word address; port p at bits [p*ADDR_WIDTH +: ADDR_WIDTH]
readData  out  NUM_READ_PORTS*DATA_WIDTH  per-port read data, packed the same way
readValid  out  NUM_READ_PORTS  per-port data-valid
writeEnable  in  1  write request
writeByteEnable  in  DATA_WIDTH/8  byte-lane mask; bit b covers bits [8b+7:8b]
writeAddress  in  ADDR_WIDTH  write word address
writeData  in  DATA_WIDTH  write data
report  in  1  when high, print per-cycle port state via $display

Behaviour:
- Reset (async, active-high):
  - ready=0, readValid=0, readData=0 (registered outputs), cycle counter=0.
  - FSM enters CLEAR if CLEAR_ON_RESET=1, else READY.
  - Array contents are not reset by the reset edge itself.
- FSM CLEAR:
  - clearAddr starts at 0; each clock writes all-zero word to sram[clearAddr], then clearAddr+1.
  - After writing MEM_DEPTH-1, go to READY on the next edge. Clear takes exactly MEM_DEPTH cycles; ready rises in cycle MEM_DEPTH after reset deassertion.
  - While in CLEAR: external writes ignored; readValid=0; readData=0.
  - Reset asserted mid-CLEAR restarts at clearAddr=0.
- FSM READY: stays in READY until reset. ready=1.
- Write (READY only):
  - On the rising edge, lane b of sram[writeAddress] <= writeData lane b when writeEnable & writeByteEnable[b].
  - Unmasked lanes are unchanged. writeByteEnable=0 with writeEnable=1 is a no-op.
- Read, READ_LATENCY=0:
  - readData[p] = bypassed word (below) when readEnable[p], else 0.
  - readValid[p] = readEnable[p] & ready, combinational.
- Read, READ_LATENCY=1:
  - At the edge where readEnable[p] & ready, register the bypassed word into readData[p] and set readValid[p]=1 for one cycle.
  - Otherwise readData[p] <= 0 and readValid[p] <= 0.
  - Data is available 1 cycle after the request.
- Bypass (read-during-write, same cycle, same address, any port):
  - Returned word is the byte-wise merge: lane b = writeData lane b if writeByteEnable[b], else the stored lane.
  - A read therefore always observes the post-write value.
  - Different addresses: no interaction.
- Multiple ports may read the same address in the same cycle; all receive identical data.
- Address width: addresses are used modulo MEM_DEPTH (no out-of-range case).
- Report:
  - 32-bit cycle counter increments every clock, wraps at 2^32.
  - When report=1, $display CORE, cycle, state, and per-port enable/address/data/valid, plus write enable/mask/address/data.

Test Plan:
- Reset clear, DEPTH=256, CLEAR_ON_RESET=1, after preloading sram[5]=32'hDEADBEEF:
  - ready=0 for cycles 0..255; ready=1 from cycle 256.
  - Read addr 5 -> 32'h00000000.
  - readValid=0 for any read issued while ready=0.
- Byte-masked write:
  - Write 32'h11223344 to addr 3 (mask 4'hF), then write 32'hAABBCCDD to addr 3 with mask 4'b0101.
  - Read addr 3 -> 32'h11BB33DD.
- Bypass, LAT=1:
  - Same cycle: write 32'hCAFEF00D mask 4'b0011 to addr 7 (old value 32'h12345678) while port 0 and port 1 both read addr 7.
  - Next cycle both readData = 32'h1234F00D, readValid=2'b11.
- Independent ports, LAT=0:
  - sram[1]=32'hA, sram[2]=32'hB.
  - Port 0 reads 1 and port 1 reads 2 -> same cycle 32'hA / 32'hB, readValid=2'b11.
  - Deassert readEnable[1] -> readData port 1 = 0, readValid[1]=0.
- Reset mid-clear:
  - Assert reset at clear cycle 100 for 2 cycles.
  - ready asserts exactly 256 cycles after release; a write attempted during clear (addr 200, 32'hFFFFFFFF) is ignored -> read addr 200 = 0.
- CLEAR_ON_RESET=0: ready=1 on the first edge after reset release; write/read at addr 255 wraps correctly (addr 8'hFF).
